mem_bus_access_unit: RTL and testbench

- Parametrised, multi-cycle successor to the combinational MEM stage.
- Accepts one load/store/LL/SC request per transaction from EX/MEM and runs a req/ack handshake on a variable-latency data bus.
- Big-endian byte-lane steering and load sign/zero extension work for 32- or 64-bit data paths.
- Owns the LLbit, raises a pipeline stall while a transaction is in flight, and bounds bus wait with a timeout.

---
 rtl/mem_bus_access_unit.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_mem_bus_access_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_access_unit.sv
// ---------------------------------------------------------------------------
// mem_bus_access_unit
//
// Multi-cycle memory access stage. It takes one load/store/LL/SC request from
// EX/MEM, runs a req/ack handshake on a variable-latency data bus, steers
// big-endian byte lanes and returns a one-cycle write-back strobe. It owns the
// LLbit, stalls the upstream pipeline while busy and gives up on the bus after
// TIMEOUT_CYC cycles without an ack.
//
// Parameters
//   DATA_W      : data bus width, 32 or 64 only
//   ADDR_W      : address width
//   TIMEOUT_CYC : max REQ cycles without bus_ack (0 = wait forever)
//
// Ports
//   clk, rst          : clock; synchronous active-low reset (0 = reset)
//   op_*              : request fields, sampled only in IDLE when op_valid=1
//   llbit_clr         : clears the LLbit (exception return)
//   stall_req         : hold upstream stages
//   wb_valid/wd/wreg/wdata : one-cycle write-back result
//   bus_req/we/addr/sel/wdata, bus_ack, bus_rdata : data bus handshake
//   timeout_err       : one-cycle pulse, coincident with wb_valid, on timeout
//   llbit_o           : current LLbit
//
// Optional feature (macro MEM_ALIGN_EXC_EN)
//   Adds align_exc / align_badvaddr. Misaligned half/word/dword requests skip
//   the bus and report an alignment exception instead of being truncated.
//
// Lane convention: byte offset k lives in bits [DATA_W-1-8k -: 8] and is
// enabled by bus_sel[NB-1-k] (MSB of bus_sel = lowest address).
// ---------------------------------------------------------------------------
module mem_bus_access_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  input  logic                  op_store,
  input  logic [1:0]            op_size,
  input  logic                  op_unsigned,
  input  logic                  op_ll,
  input  logic                  op_sc,
  input  logic [ADDR_W-1:0]     op_addr,
  input  logic [DATA_W-1:0]     op_wdata,
  input  logic [4:0]            op_wd,
  input  logic                  op_wreg,
  input  logic                  llbit_clr,
  output logic                  stall_req,
  output logic                  wb_valid,
  output logic [4:0]            wb_wd,
  output logic                  wb_wreg,
  output logic [DATA_W-1:0]     wb_wdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_sel,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic                  timeout_err,
  output logic                  llbit_o
`ifdef MEM_ALIGN_EXC_EN
  ,
  output logic                  align_exc,
  output logic [ADDR_W-1:0]     align_badvaddr
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t             state_reg;
  logic               llbit_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               store_reg;
  logic               sc_reg;
  logic               ll_reg;
  logic               uns_reg;
  logic [1:0]         size_reg;
  logic [OFF_W-1:0]   aoff_reg;
  logic [4:0]         wd_reg;
  logic               wreg_reg;

  // ---------------- request decode (used in IDLE) ----------------
  logic [OFF_W-1:0]   off_in;
  logic [OFF_W-1:0]   size_mask;
  logic [OFF_W-1:0]   aoff_in;
  logic               illegal_in;
  logic [NB-1:0]      sel_in;
  logic [DATA_W-1:0]  wdata_in;
  logic               is_write_in;

  assign off_in      = op_addr[OFF_W-1:0];
  // Low offset bits that fall inside the access; clearing them gives the
  // naturally aligned offset (misaligned bits are simply dropped).
  assign size_mask   = OFF_W'((32'd1 << op_size) - 32'd1);
  assign aoff_in     = off_in & ~size_mask;
  assign illegal_in  = (op_size == 2'b11) && (DATA_W == 32);
  assign is_write_in = op_store || op_sc;

  // A lane belongs to the access when its offset, with the in-access bits
  // cleared, equals the aligned start offset.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_sel
      assign sel_in[NB-1-gi] = ((OFF_W'(gi) & ~size_mask) == aoff_in);
    end
  endgenerate

  always_comb begin
    wdata_in = op_wdata;
    case (op_size)
      2'b00:   wdata_in = {NB{op_wdata[7:0]}};
      2'b01:   wdata_in = {(NB/2){op_wdata[15:0]}};
      2'b10:   wdata_in = {(NB/4){op_wdata[31:0]}};
      default: wdata_in = op_wdata;
    endcase
  end

`ifdef MEM_ALIGN_EXC_EN
  logic misal_in;
  assign misal_in = |(off_in & size_mask);
`endif

  // ---------------- load alignment (used on the ack edge) ----------------
  // Shift the addressed datum to the top of the word, then extend.
  logic [DATA_W-1:0]  rd_shift;
  logic [DATA_W-1:0]  ld_data;

  assign rd_shift = bus_rdata << {aoff_reg, 3'b000};

  always_comb begin
    ld_data = rd_shift;
    case (size_reg)
      2'b00: ld_data = uns_reg ? DATA_W'(rd_shift[DATA_W-1 -: 8])
                               : DATA_W'($signed(rd_shift[DATA_W-1 -: 8]));
      2'b01: ld_data = uns_reg ? DATA_W'(rd_shift[DATA_W-1 -: 16])
                               : DATA_W'($signed(rd_shift[DATA_W-1 -: 16]));
      2'b10: ld_data = uns_reg ? DATA_W'(rd_shift[DATA_W-1 -: 32])
                               : DATA_W'($signed(rd_shift[DATA_W-1 -: 32]));
      default: ld_data = rd_shift;
    endcase
  end

  // ---------------- timeout ----------------
  logic tmo_hit;
  generate
    if (TIMEOUT_CYC != 0) begin : g_tmo
      assign tmo_hit = (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  // Combinational so the upstream stage freezes in the same cycle it offers.
  assign stall_req = ((state_reg == S_IDLE) && op_valid) || (state_reg == S_REQ);
  assign llbit_o   = llbit_reg;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      llbit_reg   <= 1'b0;
      cnt_reg     <= '0;
      store_reg   <= 1'b0;
      sc_reg      <= 1'b0;
      ll_reg      <= 1'b0;
      uns_reg     <= 1'b0;
      size_reg    <= 2'b00;
      aoff_reg    <= '0;
      wd_reg      <= 5'd0;
      wreg_reg    <= 1'b0;
      wb_valid    <= 1'b0;
      wb_wd       <= 5'd0;
      wb_wreg     <= 1'b0;
      wb_wdata    <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_sel     <= '0;
      bus_wdata   <= '0;
      timeout_err <= 1'b0;
`ifdef MEM_ALIGN_EXC_EN
      align_exc      <= 1'b0;
      align_badvaddr <= '0;
`endif
    end else begin
      wb_valid    <= 1'b0;
      timeout_err <= 1'b0;
`ifdef MEM_ALIGN_EXC_EN
      align_exc   <= 1'b0;
`endif
      if (llbit_clr) begin
        llbit_reg <= 1'b0;
      end

      case (state_reg)
        S_IDLE: begin
          if (op_valid) begin
            store_reg <= op_store;
            sc_reg    <= op_sc;
            ll_reg    <= op_ll;
            uns_reg   <= op_unsigned;
            size_reg  <= op_size;
            aoff_reg  <= aoff_in;
            wd_reg    <= op_wd;
            wreg_reg  <= op_wreg;
            cnt_reg   <= '0;
            if (illegal_in) begin
              state_reg <= S_RESP;
              wb_valid  <= 1'b1;
              wb_wd     <= op_wd;
              wb_wreg   <= 1'b0;
              wb_wdata  <= '0;
            end
`ifdef MEM_ALIGN_EXC_EN
            else if (misal_in) begin
              state_reg      <= S_RESP;
              wb_valid       <= 1'b1;
              wb_wd          <= op_wd;
              wb_wreg        <= 1'b0;
              wb_wdata       <= '0;
              align_exc      <= 1'b1;
              align_badvaddr <= op_addr;
            end
`endif
            else if (op_sc && !llbit_reg) begin
              // Failed SC: report 0 to the destination without touching the bus.
              state_reg <= S_RESP;
              wb_valid  <= 1'b1;
              wb_wd     <= op_wd;
              wb_wreg   <= op_wreg;
              wb_wdata  <= '0;
            end else begin
              state_reg <= S_REQ;
              bus_req   <= 1'b1;
              bus_we    <= is_write_in;
              bus_addr  <= {op_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              bus_sel   <= sel_in;
              bus_wdata <= is_write_in ? wdata_in : '0;
            end
          end
        end

        S_REQ: begin
          if (bus_ack) begin
            state_reg <= S_RESP;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_sel   <= '0;
            bus_wdata <= '0;
            wb_valid  <= 1'b1;
            wb_wd     <= wd_reg;
            if (sc_reg) begin
              wb_wreg   <= wreg_reg;
              wb_wdata  <= DATA_W'(1);
              llbit_reg <= 1'b0;
            end else if (store_reg) begin
              wb_wreg  <= 1'b0;
              wb_wdata <= '0;
            end else begin
              wb_wreg  <= wreg_reg;
              wb_wdata <= ld_data;
              // A simultaneous llbit_clr must win over the LL set.
              if (ll_reg && !llbit_clr) begin
                llbit_reg <= 1'b1;
              end
            end
          end else if (tmo_hit) begin
            state_reg   <= S_RESP;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_sel     <= '0;
            bus_wdata   <= '0;
            wb_valid    <= 1'b1;
            wb_wd       <= wd_reg;
            wb_wreg     <= 1'b0;
            wb_wdata    <= '0;
            timeout_err <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        S_RESP: begin
          state_reg <= S_IDLE;
          wb_wd     <= 5'd0;
          wb_wreg   <= 1'b0;
          wb_wdata  <= '0;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_access_unit.sv
module tb_mem_bus_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared inputs
  logic        rst, op_store, op_unsigned, op_ll, op_sc, op_wreg, llbit_clr;
  logic [1:0]  op_size;
  logic [31:0] op_addr;
  logic [4:0]  op_wd;

  // 32-bit instance
  logic        op_valid, bus_ack;
  logic [31:0] op_wdata, bus_rdata;
  logic        stall_req, wb_valid, wb_wreg, bus_req, bus_we, timeout_err, llbit;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata, bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
`ifdef MEM_ALIGN_EXC_EN
  logic        align_exc;
  logic [31:0] align_badvaddr;
`endif

  // 64-bit instance
  logic        h_op_valid, h_bus_ack;
  logic [63:0] h_op_wdata, h_bus_rdata;
  logic        h_stall_req, h_wb_valid, h_wb_wreg, h_bus_req, h_bus_we, h_timeout_err, h_llbit;
  logic [4:0]  h_wb_wd;
  logic [63:0] h_wb_wdata, h_bus_wdata;
  logic [31:0] h_bus_addr;
  logic [7:0]  h_bus_sel;
`ifdef MEM_ALIGN_EXC_EN
  logic        h_align_exc;
  logic [31:0] h_align_badvaddr;
`endif

  mem_bus_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut32 (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_store(op_store), .op_size(op_size),
    .op_unsigned(op_unsigned), .op_ll(op_ll), .op_sc(op_sc), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_wd(op_wd), .op_wreg(op_wreg), .llbit_clr(llbit_clr),
    .stall_req(stall_req), .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .timeout_err(timeout_err), .llbit_o(llbit)
`ifdef MEM_ALIGN_EXC_EN
    , .align_exc(align_exc), .align_badvaddr(align_badvaddr)
`endif
  );

  mem_bus_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(16)) dut64 (
    .clk(clk), .rst(rst), .op_valid(h_op_valid), .op_store(op_store), .op_size(op_size),
    .op_unsigned(op_unsigned), .op_ll(op_ll), .op_sc(op_sc), .op_addr(op_addr),
    .op_wdata(h_op_wdata), .op_wd(op_wd), .op_wreg(op_wreg), .llbit_clr(llbit_clr),
    .stall_req(h_stall_req), .wb_valid(h_wb_valid), .wb_wd(h_wb_wd), .wb_wreg(h_wb_wreg),
    .wb_wdata(h_wb_wdata), .bus_req(h_bus_req), .bus_we(h_bus_we), .bus_addr(h_bus_addr),
    .bus_sel(h_bus_sel), .bus_wdata(h_bus_wdata), .bus_ack(h_bus_ack), .bus_rdata(h_bus_rdata),
    .timeout_err(h_timeout_err), .llbit_o(h_llbit)
`ifdef MEM_ALIGN_EXC_EN
    , .align_exc(h_align_exc), .align_badvaddr(h_align_badvaddr)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        tmo;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-back monitor for the 32-bit instance: pops the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b1 && wb_valid === 1'b1) begin
      chk("wb_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("wb_wd", 64'(wb_wd), 64'(mon_e.wd));
        chk("wb_wreg", 64'(wb_wreg), 64'(mon_e.wreg));
        chk("wb_wdata", 64'(wb_wdata), 64'(mon_e.wdata));
        chk("timeout_err", 64'(timeout_err), 64'(mon_e.tmo));
        chk("stall_in_resp", 64'(stall_req), 64'd0);
      end
    end
  end

  // One request on the 32-bit instance with a bus responder acking on
  // REQ cycle ack_at (0 = never).
  task automatic op32(input string tag, input logic st, input logic [1:0] sz,
                      input logic uns, input logic ll, input logic sc,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] wd, input logic wreg,
                      input int ack_at, input logic [31:0] rdata,
                      input logic exp_bus, input logic [31:0] e_addr,
                      input logic [3:0] e_sel, input logic [31:0] e_wdata,
                      input logic [31:0] e_res, input logic e_wreg,
                      input logic e_tmo, input int e_reqcyc);
    int n;
    @(negedge clk);
    op_store = st; op_size = sz; op_unsigned = uns; op_ll = ll; op_sc = sc;
    op_addr = addr; op_wdata = wdata; op_wd = wd; op_wreg = wreg; op_valid = 1'b1;
    sb.push_back('{wd: wd, wreg: e_wreg, wdata: e_res, tmo: e_tmo});
    #1;
    chk({tag, "_stall_idle"}, 64'(stall_req), 64'd1);
    @(negedge clk);
    op_valid = 1'b0;
    if (exp_bus) begin
      n = 0;
      while (bus_req === 1'b1 && n < 20) begin
        n++;
        if (n == 1) begin
          chk({tag, "_bus_addr"}, 64'(bus_addr), 64'(e_addr));
          chk({tag, "_bus_sel"}, 64'(bus_sel), 64'(e_sel));
          chk({tag, "_bus_we"}, 64'(bus_we), 64'(st | sc));
          chk({tag, "_bus_wdata"}, 64'(bus_wdata), 64'(e_wdata));
        end
        chk({tag, "_stall_req"}, 64'(stall_req), 64'd1);
        if (n == ack_at) begin
          bus_ack = 1'b1;
          bus_rdata = rdata;
        end
        @(negedge clk);
        bus_ack = 1'b0;
      end
      chk({tag, "_req_cycles"}, 64'(n), 64'(e_reqcyc));
    end else begin
      chk({tag, "_no_bus_req"}, 64'(bus_req), 64'd0);
    end
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    chk({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
  endtask

  // One load on the 64-bit instance, acked on the first REQ cycle.
  task automatic ld64(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [63:0] rdata,
                      input logic [31:0] e_addr, input logic [7:0] e_sel,
                      input logic [63:0] e_res);
    @(negedge clk);
    op_store = 1'b0; op_size = sz; op_unsigned = uns; op_ll = 1'b0; op_sc = 1'b0;
    op_addr = addr; op_wd = 5'd9; op_wreg = 1'b1; h_op_valid = 1'b1;
    @(negedge clk);
    h_op_valid = 1'b0;
    chk({tag, "_bus_req"}, 64'(h_bus_req), 64'd1);
    chk({tag, "_bus_addr"}, 64'(h_bus_addr), 64'(e_addr));
    chk({tag, "_bus_sel"}, 64'(h_bus_sel), 64'(e_sel));
    h_bus_ack = 1'b1;
    h_bus_rdata = rdata;
    @(negedge clk);
    h_bus_ack = 1'b0;
    chk({tag, "_wb_valid"}, 64'(h_wb_valid), 64'd1);
    chk({tag, "_wb_wdata"}, h_wb_wdata, e_res);
    chk({tag, "_wb_wreg"}, 64'(h_wb_wreg), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; op_valid = 1'b0; h_op_valid = 1'b0; op_store = 1'b0; op_size = 2'b00;
    op_unsigned = 1'b0; op_ll = 1'b0; op_sc = 1'b0; op_addr = '0; op_wdata = '0;
    h_op_wdata = '0; op_wd = '0; op_wreg = 1'b0; llbit_clr = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0; h_bus_ack = 1'b0; h_bus_rdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_sel", 64'(bus_sel), 64'd0);
    chk("rst_llbit", 64'(llbit), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    chk("rst_h_bus_req", 64'(h_bus_req), 64'd0);
    rst = 1'b1;

    // signed byte load, ack on 3rd REQ cycle
    op32("lb", 0, 2'b00, 0, 0, 0, 32'h101, 32'h0, 5'd3, 1, 3, 32'h12F45678,
         1, 32'h100, 4'b0100, 32'h0, 32'hFFFFFFF4, 1, 0, 3);
    // unsigned half and word loads
    op32("lhu", 0, 2'b01, 1, 0, 0, 32'h102, 32'h0, 5'd4, 1, 1, 32'h1234F678,
         1, 32'h100, 4'b0011, 32'h0, 32'h0000F678, 1, 0, 1);
    op32("lw", 0, 2'b10, 0, 0, 0, 32'h104, 32'h0, 5'd5, 1, 2, 32'h89ABCDEF,
         1, 32'h104, 4'b1111, 32'h0, 32'h89ABCDEF, 1, 0, 2);
    // stores: half and byte
    op32("sh", 1, 2'b01, 0, 0, 0, 32'h206, 32'h0000BEEF, 5'd6, 1, 1, 32'h0,
         1, 32'h204, 4'b0011, 32'hBEEFBEEF, 32'h0, 0, 0, 1);
    op32("sb", 1, 2'b00, 0, 0, 0, 32'h208, 32'h0000005A, 5'd6, 1, 1, 32'h0,
         1, 32'h208, 4'b1000, 32'h5A5A5A5A, 32'h0, 0, 0, 1);
    // illegal dword on 32-bit path
    op32("ld_illegal", 0, 2'b11, 0, 0, 0, 32'h300, 32'h0, 5'd7, 1, 1, 32'h0,
         0, 32'h0, 4'b0, 32'h0, 32'h0, 0, 0, 0);

    // LL / SC pair, then a second SC fails
    op32("ll", 0, 2'b10, 0, 1, 0, 32'h300, 32'h0, 5'd8, 1, 1, 32'hCAFEF00D,
         1, 32'h300, 4'b1111, 32'h0, 32'hCAFEF00D, 1, 0, 1);
    chk("llbit_after_ll", 64'(llbit), 64'd1);
    op32("sc_ok", 1, 2'b10, 0, 0, 1, 32'h300, 32'h000000A5, 5'd9, 1, 1, 32'h0,
         1, 32'h300, 4'b1111, 32'h000000A5, 32'h1, 1, 0, 1);
    chk("llbit_after_sc", 64'(llbit), 64'd0);
    op32("sc_fail", 1, 2'b10, 0, 0, 1, 32'h300, 32'h000000A5, 5'd9, 1, 1, 32'h0,
         0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 0, 0);

    // LL, llbit_clr pulse, SC fails
    op32("ll2", 0, 2'b10, 0, 1, 0, 32'h310, 32'h0, 5'd8, 1, 1, 32'h11223344,
         1, 32'h310, 4'b1111, 32'h0, 32'h11223344, 1, 0, 1);
    @(negedge clk); llbit_clr = 1'b1;
    @(negedge clk); llbit_clr = 1'b0;
    chk("llbit_cleared", 64'(llbit), 64'd0);
    op32("sc_after_clr", 1, 2'b10, 0, 0, 1, 32'h310, 32'h1, 5'd9, 1, 1, 32'h0,
         0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 0, 0);

    // llbit_clr held across an LL, including its completion edge: clear wins
    llbit_clr = 1'b1;
    op32("ll_clr", 0, 2'b10, 0, 1, 0, 32'h320, 32'h0, 5'd8, 1, 1, 32'h55667788,
         1, 32'h320, 4'b1111, 32'h0, 32'h55667788, 1, 0, 1);
    llbit_clr = 1'b0;
    chk("llbit_clr_wins", 64'(llbit), 64'd0);

    // late ack in IDLE is ignored
    @(negedge clk); bus_ack = 1'b1;
    @(negedge clk); bus_ack = 1'b0;
    chk("late_ack_bus_req", 64'(bus_req), 64'd0);
    chk("late_ack_wb_valid", 64'(wb_valid), 64'd0);

    // timeout on an SC after LL: LLbit stays set
    op32("ll3", 0, 2'b10, 0, 1, 0, 32'h330, 32'h0, 5'd8, 1, 1, 32'h0BADF00D,
         1, 32'h330, 4'b1111, 32'h0, 32'h0BADF00D, 1, 0, 1);
    op32("sc_tmo", 1, 2'b10, 0, 0, 1, 32'h330, 32'h77, 5'd9, 1, 0, 32'h0,
         1, 32'h330, 4'b1111, 32'h77, 32'h0, 0, 1, 4);
    chk("llbit_after_tmo", 64'(llbit), 64'd1);

    // reset during REQ aborts with no write-back
    @(negedge clk);
    op_store = 1'b0; op_size = 2'b10; op_ll = 1'b0; op_sc = 1'b0; op_addr = 32'h400;
    op_valid = 1'b1;
    @(negedge clk); op_valid = 1'b0;
    chk("abort_req_on", 64'(bus_req), 64'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("abort_bus_req", 64'(bus_req), 64'd0);
    chk("abort_wb_valid", 64'(wb_valid), 64'd0);
    chk("abort_llbit", 64'(llbit), 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    op32("post_rst", 0, 2'b00, 1, 0, 0, 32'h403, 32'h0, 5'd2, 1, 1, 32'hA1B2C3D4,
         1, 32'h400, 4'b0001, 32'h0, 32'h000000D4, 1, 0, 1);

    // 64-bit data path
    ld64("ld64", 2'b11, 1, 32'h08, 64'h0123456789ABCDEF, 32'h08, 8'hFF, 64'h0123456789ABCDEF);
    ld64("lw64", 2'b10, 0, 32'h0C, 64'h0123456789ABCDEF, 32'h08, 8'h0F, 64'hFFFFFFFF89ABCDEF);
`ifdef MEM_ALIGN_EXC_EN
    @(negedge clk);
    op_store = 1'b0; op_size = 2'b10; op_unsigned = 1'b1; op_addr = 32'h0A; op_wreg = 1'b1;
    h_op_valid = 1'b1;
    @(negedge clk); h_op_valid = 1'b0;
    chk("aexc_bus_req", 64'(h_bus_req), 64'd0);
    chk("aexc_wb_valid", 64'(h_wb_valid), 64'd1);
    chk("aexc_pulse", 64'(h_align_exc), 64'd1);
    chk("aexc_badvaddr", 64'(h_align_badvaddr), 64'h0A);
    chk("aexc_wb_wreg", 64'(h_wb_wreg), 64'd0);
`else
    ld64("lw64_trunc", 2'b10, 1, 32'h0A, 64'h0123456789ABCDEF, 32'h08, 8'hF0, 64'h0000000001234567);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
